// File: rtl/adc_avg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// adc_avg_pkg : state encoding and width helpers for adc_sample_averager
// Rev 1.0
// ============================================================================
package adc_avg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_START     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    function automatic int acc_w(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    // Bits needed to count 0..n-1.
    function automatic int ctr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_averager_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// adc_sample_averager_if : start/busy/new_data/data handshake to mcp3201_spi
// Rev 1.0
// ============================================================================
interface adc_sample_averager_if #(
    parameter int DATA_W = 12
);
    logic              adc_start;
    logic              adc_busy;
    logic              adc_new_data;
    logic [DATA_W-1:0] adc_data;

    modport master (
        output adc_start,
        input  adc_busy,
        input  adc_new_data,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        output adc_busy,
        output adc_new_data,
        output adc_data
    );
endinterface
`default_nettype wire

// File: rtl/adc_sample_averager_sample_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sample_tick_gen : free-running 0..PERIOD-1 timer, tick on the last count
// Rev 1.0
// ============================================================================
module sample_tick_gen
    import adc_avg_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic enable,
    output logic      tick
);
    localparam int              c_W    = ctr_w(PERIOD);
    localparam logic [c_W-1:0]  c_LAST = c_W'(PERIOD - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/adc_sample_averager.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// adc_sample_averager : periodic ADC trigger, 2^AVG_LOG2 averaging, flags
// Rev 1.0
// ============================================================================
module adc_sample_averager
    import adc_avg_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int AVG_LOG2      = 2,
    parameter int DATA_W        = 12,
    parameter int TIMEOUT       = 4096
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               enable,
    input  wire logic               clear_flags,
    adc_sample_averager_if.master   adc,
    output logic [DATA_W-1:0]       avg_out,
    output logic                    avg_valid,
    output logic                    overrun,
    output logic                    timeout
);
    localparam int                 c_ACC_W    = acc_w(DATA_W, AVG_LOG2);
    localparam int                 c_TO_W     = ctr_w(TIMEOUT);
    localparam int                 c_CNT_W    = AVG_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'((1 << AVG_LOG2) - 1);
    // Fires when the counter is about to become TIMEOUT-1, so the flag lands
    // TIMEOUT cycles after the start pulse.
    localparam logic [c_TO_W-1:0]  c_TO_HIT   = c_TO_W'(TIMEOUT - 2);

    state_t             r_state;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TO_W-1:0]  r_tcnt;
    logic               r_adc_start;

    logic               w_tick;
    logic [c_ACC_W-1:0] w_sum;
    logic               w_to_hit;
    logic               w_ov_set;
    logic               w_to_set;

    sample_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (w_tick)
    );

    assign w_sum    = r_acc + c_ACC_W'(adc.adc_data);
    assign w_to_hit = (r_tcnt == c_TO_HIT);
    assign w_ov_set = w_tick && (((r_state == ST_WAIT_TICK) && adc.adc_busy) ||
                                 (r_state == ST_WAIT_DONE));
    assign w_to_set = (r_state == ST_WAIT_DONE) && !adc.adc_new_data && w_to_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_adc_start <= 1'b0;
            avg_out     <= '0;
            avg_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_adc_start <= 1'b0;
            avg_valid   <= 1'b0;

            // A set event in the same cycle as clear_flags takes priority.
            if (w_ov_set)         overrun <= 1'b1;
            else if (clear_flags) overrun <= 1'b0;
            if (w_to_set)         timeout <= 1'b1;
            else if (clear_flags) timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (enable) r_state <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick && !adc.adc_busy) begin
                        r_state     <= ST_START;
                        r_adc_start <= 1'b1;
                    end
                end
                ST_START: begin
                    r_tcnt  <= '0;
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (adc.adc_new_data) begin
                        // With enable low the sample and partial sum are dropped.
                        if (!enable) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_TICK;
                            if (r_cnt == c_LAST_CNT) begin
                                avg_out   <= DATA_W'(w_sum >> AVG_LOG2);
                                avg_valid <= 1'b1;
                                r_acc     <= '0;
                                r_cnt     <= '0;
                            end else begin
                                r_acc <= w_sum;
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end else if (w_to_hit) begin
                        r_state <= enable ? ST_WAIT_TICK : ST_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign adc.adc_start = r_adc_start;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_averager.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_adc_sample_averager : directed bench with a behavioural ADC reader model
// Rev 1.0
// ============================================================================
module tb_adc_sample_averager;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear_flags;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic        overrun;
    logic        timeout;

    adc_sample_averager_if #(.DATA_W(12)) bus ();

    adc_sample_averager #(
        .SAMPLE_PERIOD (100),
        .AVG_LOG2      (2),
        .DATA_W        (12),
        .TIMEOUT       (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_flags (clear_flags),
        .adc         (bus),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and event monitor, both evaluated on the falling edge.
    logic [11:0] q[$];
    int  busy_len = 40;
    bit  respond  = 1'b1;
    int  busy_rem = 0;
    int  start_cnt = 0, nd_cnt = 0, avg_cnt = 0;
    int  last_start_cyc = 0, prev_start_cyc = 0, last_nd_cyc = 0, last_avg_cyc = 0;

    initial begin
        bus.adc_busy     = 1'b0;
        bus.adc_new_data = 1'b0;
        bus.adc_data     = '0;
    end

    always @(negedge clk) begin
        if (avg_valid) begin
            avg_cnt++;
            last_avg_cyc = cyc;
        end
        bus.adc_new_data = 1'b0;
        if (busy_rem > 0) begin
            busy_rem--;
            if (busy_rem == 0) begin
                bus.adc_busy     = 1'b0;
                bus.adc_new_data = 1'b1;
                bus.adc_data     = (q.size() > 0) ? q.pop_front() : 12'h000;
                nd_cnt++;
                last_nd_cyc = cyc;
            end
        end
        if (bus.adc_start) begin
            start_cnt++;
            prev_start_cyc = last_start_cyc;
            last_start_cyc = cyc;
            if (respond && busy_rem == 0) begin
                bus.adc_busy = 1'b1;
                busy_rem     = busy_len;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_cycle();
        @(negedge clk);
        #1;
    endtask

    // which: 0 starts, 1 new_data, 2 averages, 3 overrun, 4 timeout
    task automatic wait_ev(input string tag, input int which, input int target, input int bound);
        int v;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound; i++) begin
            wait_cycle();
            case (which)
                0:       v = start_cnt;
                1:       v = nd_cnt;
                2:       v = avg_cnt;
                3:       v = int'(overrun);
                4:       v = int'(timeout);
                default: v = 0;
            endcase
            if (v >= target) begin
                hit = 1'b1;
                break;
            end
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic push4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
        q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
    endtask

    task automatic run_avg(input string tag, input logic [11:0] exp);
        int abase;
        abase = avg_cnt;
        enable = 1'b1;
        wait_ev({tag, "_wait"}, 2, abase + 1, 1000);
        check(tag, 32'(avg_out), 32'(exp));
    endtask

    int sbase, nbase, abase, s2, t_to;

    initial begin
        rst = 1'b1; enable = 1'b0; clear_flags = 1'b0;
        repeat (3) wait_cycle();
        check("rst_avg_out",   32'(avg_out),       32'h0);
        check("rst_avg_valid", 32'(avg_valid),     32'h0);
        check("rst_overrun",   32'(overrun),       32'h0);
        check("rst_timeout",   32'(timeout),       32'h0);
        check("rst_adc_start", 32'(bus.adc_start), 32'h0);
        rst = 1'b0;
        wait_cycle();

        // Basic average, latency and start spacing.
        push4(12'h100, 12'h102, 12'h104, 12'h106);
        abase = avg_cnt;
        run_avg("avg_103", 12'h103);
        check("avg_latency", 32'(last_avg_cyc - last_nd_cyc), 32'd1);
        check("start_spacing", 32'(last_start_cyc - prev_start_cyc), 32'd100);
        repeat (5) wait_cycle();
        check("one_avg_valid", 32'(avg_cnt - abase), 32'd1);

        push4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        run_avg("avg_fff", 12'hFFF);
        push4(12'h000, 12'h000, 12'h000, 12'h000);
        run_avg("avg_000", 12'h000);
        enable = 1'b0;
        repeat (3) wait_cycle();

        // Overrun: conversion outlasts the tick period.
        busy_len = 150;
        q.push_back(12'h555);
        sbase = start_cnt; abase = avg_cnt;
        enable = 1'b1;
        wait_ev("ovr_wait", 3, 1, 400);
        check("ovr_no_extra_start", 32'(start_cnt - sbase), 32'd1);
        check("ovr_timeout_too", 32'(timeout), 32'd1);
        clear_flags = 1'b1;
        wait_cycle();
        clear_flags = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_timeout", 32'(timeout), 32'd0);
        enable = 1'b0;
        repeat (200) wait_cycle();
        check("ovr_no_avg", 32'(avg_cnt - abase), 32'd0);

        // Timeout between samples must leave the partial sum untouched.
        busy_len = 40;
        respond  = 1'b1;
        q.delete();
        q.push_back(12'h040);
        sbase = start_cnt; nbase = nd_cnt;
        enable = 1'b1;
        wait_ev("to_nd1", 1, nbase + 1, 300);
        respond = 1'b0;
        wait_ev("to_start2", 0, sbase + 2, 300);
        s2 = last_start_cyc;
        wait_ev("to_wait", 4, 1, 200);
        t_to = cyc;
        check("to_delay", 32'(t_to - s2), 32'd64);
        respond = 1'b1;
        q.push_back(12'h080); q.push_back(12'h0C0); q.push_back(12'h100);
        wait_ev("to_start3", 0, sbase + 3, 300);
        check("to_restart_spacing", 32'(last_start_cyc - s2), 32'd100);
        run_avg("avg_after_to", 12'h0A0);

        // Enable dropped mid-conversion after two samples.
        enable = 1'b0;
        repeat (3) wait_cycle();
        q.push_back(12'h200); q.push_back(12'h200); q.push_back(12'h300);
        sbase = start_cnt; nbase = nd_cnt; abase = avg_cnt;
        enable = 1'b1;
        wait_ev("dis_nd2", 1, nbase + 2, 400);
        wait_ev("dis_start3", 0, sbase + 3, 300);
        repeat (5) wait_cycle();
        enable = 1'b0;
        repeat (150) wait_cycle();
        check("dis_nd_taken", 32'(nd_cnt - nbase), 32'd3);
        check("dis_no_start", 32'(start_cnt - sbase), 32'd3);
        check("dis_no_avg", 32'(avg_cnt - abase), 32'd0);
        check("dis_avg_held", 32'(avg_out), 32'h0A0);
        push4(12'h010, 12'h010, 12'h010, 12'h010);
        run_avg("avg_reenable", 12'h010);

        // Reset pulse during WAIT_DONE; the late new_data must be ignored.
        q.push_back(12'h7FF);
        sbase = start_cnt;
        wait_ev("rst_start", 0, sbase + 1, 300);
        repeat (10) wait_cycle();
        rst = 1'b1;
        wait_cycle();
        rst = 1'b0;
        check("mid_rst_avg_out",   32'(avg_out),       32'h0);
        check("mid_rst_avg_valid", 32'(avg_valid),     32'h0);
        check("mid_rst_overrun",   32'(overrun),       32'h0);
        check("mid_rst_timeout",   32'(timeout),       32'h0);
        check("mid_rst_adc_start", 32'(bus.adc_start), 32'h0);
        push4(12'h030, 12'h030, 12'h030, 12'h030);
        run_avg("avg_after_rst", 12'h030);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Control and post-processing stage directly upstream and downstream of mcp3201_spi.
- Issues periodic start pulses to the SPI ADC reader and consumes its 12-bit data_out/new_data.
- Accumulates 2^AVG_LOG2 conversions and emits one truncated average with a single-cycle valid strobe.
- Flags missed sample ticks (overrun) and conversions that never complete (timeout).

Parameters:
- SAMPLE_PERIOD, 1000: clk cycles between conversion requests; must be >= 2.
- AVG_LOG2, 2: log2 of samples per average; legal range 0..8.
- DATA_W, 12: ADC sample width.
- TIMEOUT, 4096: max clk cycles from start to new_data before aborting that conversion.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run periodic sampling.
- clear_flags  in  1  one-cycle pulse; clears overrun and timeout.
- adc_start  out  1  one-cycle start pulse to mcp3201_spi.start.
- adc_busy  in  1  from mcp3201_spi.busy.
- adc_new_data  in  1  from mcp3201_spi.new_data; one-cycle pulse.
- adc_data  in  DATA_W  from mcp3201_spi.data_out; valid when adc_new_data=1.
- avg_out  out  DATA_W  last completed average; held until the next one.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- overrun  out  1  sticky: a tick arrived while a conversion was outstanding.
- timeout  out  1  sticky: a conversion exceeded TIMEOUT.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, sample counter, tick timer and timeout counter 0.
- Tick timer:
  - Runs only while enable=1; counts 0..SAMPLE_PERIOD-1 and wraps.
  - tick=1 on the cycle the count equals SAMPLE_PERIOD-1.
  - Held at 0 while enable=0.
- State IDLE:
  - enable=1 -> WAIT_TICK.
  - Accumulator and sample counter cleared on entry.
- State WAIT_TICK:
  - tick & !adc_busy -> START.
  - tick & adc_busy -> overrun<=1; stay.
  - enable=0 -> IDLE.
- State START:
  - adc_start=1 for exactly this cycle.
  - Timeout counter <= 0.
  - -> WAIT_DONE.
- State WAIT_DONE:
  - adc_new_data=1 -> acc <= acc + adc_data; cnt <= cnt+1; -> WAIT_TICK (or IDLE if enable=0).
  - Timeout counter reaches TIMEOUT-1 -> timeout<=1; sample discarded; -> WAIT_TICK.
  - A tick in this state sets overrun<=1 and is not queued.
  - enable=0 here: remain in WAIT_DONE until new_data or timeout (the ADC transfer cannot be aborted), discard the sample, then -> IDLE; partial accumulation is dropped.
- Average:
  - Accumulator width is DATA_W+AVG_LOG2, so there is no overflow.
  - On the new_data that completes 2^AVG_LOG2 samples: avg_out <= (acc+adc_data)>>AVG_LOG2 (truncating); avg_valid=1 on the following cycle; acc and cnt cleared in the same update.
  - Latency: avg_valid and avg_out change 1 cycle after the final adc_new_data.
- adc_new_data outside WAIT_DONE is ignored.
- clear_flags:
  - Clears overrun and timeout.
  - If a set event coincides with clear_flags, the set wins.
- Reset mid-operation: everything returns to reset values next cycle. The ADC block shares rst, so no stale new_data is expected; if one arrives, it is ignored per the rule above.

Decomposition:
- Package adc_avg_pkg holds:
  - the state encoding (IDLE, WAIT_TICK, START, WAIT_DONE);
  - width helpers: accumulator width DATA_W+AVG_LOG2, and counter widths via clog2 of SAMPLE_PERIOD and TIMEOUT.
- One sub-module, sample_tick_gen (parameter PERIOD; ports clk, rst, enable, tick), holds the tick timer. Everything else stays in the top.

Test Plan:
- SAMPLE_PERIOD=100, AVG_LOG2=2, ADC model busy 40 cycles, returns 0x100, 0x102, 0x104, 0x106 -> exactly one avg_valid with avg_out=0x103, 1 cycle after the 4th new_data; adc_start pulses spaced 100 cycles.
- Four samples of 0xFFF -> avg_out=0xFFF (no wrap). Four samples of 0x000 -> avg_out=0x000.
- ADC busy 150 cycles with SAMPLE_PERIOD=100 -> overrun=1 after the first missed tick, with no extra adc_start while busy. clear_flags -> overrun=0 next cycle.
- ADC never returns new_data, TIMEOUT=64 -> timeout=1 exactly 64 cycles after adc_start; the next tick issues a new adc_start; the accumulator is unchanged.
- enable dropped after 2 of 4 samples, mid-conversion -> the block waits for new_data, then enters IDLE with no avg_valid. Re-enable with 4 samples of 0x010 -> avg_out=0x010 (stale partial sum discarded).
- rst asserted for 1 cycle during WAIT_DONE -> all outputs 0 next cycle; a later new_data is ignored; sampling restarts cleanly after rst is released.
